// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter for the per-core data masters of the coherent multicore intercon.
// Every write is preceded by a snoop broadcast and waits for acks or a timeout before it is granted.
module snoop_bus_arbiter #(
  parameter int NUM_CORES     = 2,
  parameter int SNOOP_TIMEOUT = 15
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NUM_CORES-1:0]    m_cyc_i,
  input  logic [NUM_CORES-1:0]    m_stb_i,
  input  logic [NUM_CORES-1:0]    m_we_i,
  input  logic [32*NUM_CORES-1:0] m_adr_i,
  output logic [NUM_CORES-1:0]    grant_o,
  output logic [3:0]              grant_idx_o,
  output logic                    snoop_req_o,
  output logic [32*NUM_CORES-1:0] snoop_adr_o,
  input  logic [NUM_CORES-1:0]    snoop_ack_i,
  input  logic [NUM_CORES-1:0]    snoop_hit_i,
  output logic                    snoop_hit_o,
  output logic                    snoop_timeout_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SNOOP    = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;
  localparam logic [1:0] S_GRANT    = 2'd3;

  localparam logic [7:0] TIMER_LAST = 8'(SNOOP_TIMEOUT - 1);
  localparam logic [3:0] LAST_CORE  = 4'(NUM_CORES - 1);

  logic [1:0]           state_q, state_d;
  logic [3:0]           ptr_q, ptr_d;
  logic [3:0]           win_q, win_d;
  logic [31:0]          adr_q, adr_d;
  logic [NUM_CORES-1:0] ack_seen_q, ack_seen_d;
  logic [NUM_CORES-1:0] hit_acc_q, hit_acc_d;
  logic [7:0]           timer_q, timer_d;
  logic                 snoop_hit_q, snoop_hit_d;

  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] win_oh;
  logic [NUM_CORES-1:0] ack_now;
  logic [NUM_CORES-1:0] hit_now;
  logic                 hi_found, any_found;
  logic [3:0]           hi_idx, any_idx, pick;
  logic [31:0]          pick_adr;
  logic                 pick_we;
  logic                 own_cyc;
  logic                 timeout_pulse;

  assign req     = m_cyc_i & m_stb_i;
  assign own_cyc = |(m_cyc_i & win_oh);
  assign ack_now = ack_seen_q | snoop_ack_i;
  assign hit_now = hit_acc_q | (snoop_hit_i & snoop_ack_i & ~win_oh);

  // Round-robin pick: first requester at or above the pointer, else the lowest requester (wrap).
  // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
  always_comb begin
    hi_found  = 1'b0;
    any_found = 1'b0;
    hi_idx    = 4'd0;
    any_idx   = 4'd0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (req[k] && !any_found) begin
        any_found = 1'b1;
        any_idx   = 4'(k);
      end
      if (req[k] && !hi_found && (4'(k) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = 4'(k);
      end
    end
    pick = hi_found ? hi_idx : any_idx;
  end

  always_comb begin
    pick_adr = 32'd0;
    pick_we  = 1'b0;
    win_oh   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (pick == 4'(k)) begin
        pick_adr = m_adr_i[32*k +: 32];
        pick_we  = m_we_i[k];
      end
      win_oh[k] = (win_q == 4'(k));
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    adr_d         = adr_q;
    ack_seen_d    = ack_seen_q;
    hit_acc_d     = hit_acc_q;
    timer_d       = timer_q;
    snoop_hit_d   = snoop_hit_q;
    timeout_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_found) begin
          win_d   = pick;
          adr_d   = pick_adr;
          state_d = pick_we ? S_SNOOP : S_GRANT;
        end
      end
      S_SNOOP: begin
        // Own core is preset as acked; acks already present in this cycle count too.
        ack_seen_d = win_oh | snoop_ack_i;
        hit_acc_d  = snoop_hit_i & snoop_ack_i & ~win_oh;
        timer_d    = 8'd0;
        state_d    = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        ack_seen_d = ack_now;
        hit_acc_d  = hit_now;
        timer_d    = timer_q + 8'd1;
        if (&ack_now) begin
          state_d     = S_GRANT;
          snoop_hit_d = |hit_now;
        end else if (timer_q == TIMER_LAST) begin
          timeout_pulse = 1'b1;
          state_d       = S_GRANT;
          snoop_hit_d   = |hit_now;
        end
      end
      default: begin
        if (!own_cyc) begin
          state_d = S_IDLE;
          ptr_d   = (win_q == LAST_CORE) ? 4'd0 : win_q + 4'd1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= 4'd0;
      win_q       <= 4'd0;
      adr_q       <= 32'd0;
      ack_seen_q  <= '0;
      hit_acc_q   <= '0;
      timer_q     <= 8'd0;
      snoop_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      adr_q       <= adr_d;
      ack_seen_q  <= ack_seen_d;
      hit_acc_q   <= hit_acc_d;
      timer_q     <= timer_d;
      snoop_hit_q <= snoop_hit_d;
    end
  end

  assign grant_o         = (state_q == S_GRANT) ? win_oh : '0;
  assign grant_idx_o     = (state_q == S_GRANT) ? win_q : 4'd0;
  assign snoop_req_o     = (state_q == S_SNOOP);
  assign snoop_adr_o     = ((state_q == S_SNOOP) || (state_q == S_WAIT_ACK)) ?
                           {NUM_CORES{adr_q}} : '0;
  assign snoop_hit_o     = snoop_hit_q;
  assign snoop_timeout_o = timeout_pulse;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: a 4-core instance for read arbitration and
// a 2-core instance for snoop, timeout and reset behaviour.
module tb_snoop_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-core instance
  logic [3:0]   a_cyc, a_stb, a_we, a_ack, a_hit, a_grant;
  logic [127:0] a_adr, a_sadr;
  logic [3:0]   a_idx;
  logic         a_sreq, a_shit, a_tout;

  // 2-core instance
  logic [1:0]   b_cyc, b_stb, b_we, b_ack, b_hit, b_grant;
  logic [63:0]  b_adr, b_sadr;
  logic [3:0]   b_idx;
  logic         b_sreq, b_shit, b_tout;

  int checks = 0;
  int errors = 0;

  snoop_bus_arbiter #(.NUM_CORES(4), .SNOOP_TIMEOUT(15)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(a_cyc), .m_stb_i(a_stb), .m_we_i(a_we), .m_adr_i(a_adr),
    .grant_o(a_grant), .grant_idx_o(a_idx),
    .snoop_req_o(a_sreq), .snoop_adr_o(a_sadr),
    .snoop_ack_i(a_ack), .snoop_hit_i(a_hit),
    .snoop_hit_o(a_shit), .snoop_timeout_o(a_tout)
  );

  snoop_bus_arbiter #(.NUM_CORES(2), .SNOOP_TIMEOUT(15)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we), .m_adr_i(b_adr),
    .grant_o(b_grant), .grant_idx_o(b_idx),
    .snoop_req_o(b_sreq), .snoop_adr_o(b_sadr),
    .snoop_ack_i(b_ack), .snoop_hit_i(b_hit),
    .snoop_hit_o(b_shit), .snoop_timeout_o(b_tout)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watch dut2 for up to 20 cycles after SNOOP; report when the timeout pulsed and the grant appeared.
  task automatic watch_timeout(output int t_at, output int pulses, output int g_at);
    t_at = -1; pulses = 0; g_at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (b_tout) begin
        pulses++;
        t_at = i;
      end
      if (b_grant != 2'b00 && g_at < 0) g_at = i;
    end
  endtask

  int t_at, pulses, g_at;
  int order [5] = '{0, 1, 2, 3, 0};
  logic [3:0] oh;

  initial begin
    rst = 1'b1;
    a_cyc = '0; a_stb = '0; a_we = '0; a_ack = '0; a_hit = '0; a_adr = '0;
    b_cyc = '0; b_stb = '0; b_we = '0; b_ack = '0; b_hit = '0; b_adr = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_grant",   128'(a_grant), 128'h0);
    check("rst_idx",     128'(a_idx),   128'h0);
    check("rst_sreq",    128'(a_sreq),  128'h0);
    check("rst_sadr",    a_sadr,        128'h0);
    check("rst_shit",    128'(a_shit),  128'h0);
    check("rst_timeout", 128'(a_tout),  128'h0);

    // Core2 read alone: grant one cycle later, no snoop.
    a_cyc = 4'b0100; a_stb = 4'b0100;
    tick();
    check("rd2_grant", 128'(a_grant), 128'h4);
    check("rd2_idx",   128'(a_idx),   128'h2);
    check("rd2_sreq",  128'(a_sreq),  128'h0);
    tick();
    check("rd2_hold",  128'(a_grant), 128'h4);
    a_cyc = 4'b0000; a_stb = 4'b0000;
    tick();
    check("rd2_release", 128'(a_grant), 128'h0);
    // Pointer is now 3: core3 beats core0.
    a_cyc = 4'b1001; a_stb = 4'b1001;
    tick();
    check("ptr3_grant", 128'(a_grant), 128'h8);
    check("ptr3_idx",   128'(a_idx),   128'h3);
    a_cyc = 4'b0000; a_stb = 4'b0000;
    tick();
    check("ptr3_release", 128'(a_grant), 128'h0);

    // All four reading continuously; each owner drops cyc after three granted cycles.
    a_cyc = 4'b1111; a_stb = 4'b1111;
    foreach (order[n]) begin
      oh = 4'b0001 << order[n];
      for (int c = 0; c < 3; c++) begin
        tick();
        check($sformatf("rr%0d_grant", n), 128'(a_grant), 128'(oh));
      end
      a_cyc = a_cyc & ~oh; a_stb = a_stb & ~oh;
      tick();
      check($sformatf("rr%0d_idle", n), 128'(a_grant), 128'h0);
      a_cyc = a_cyc | oh; a_stb = a_stb | oh;
    end
    a_cyc = '0; a_stb = '0;

    // 2-core: core0 write to 0x1040, core1 acks with hit two cycles after SNOOP.
    b_cyc = 2'b01; b_stb = 2'b01; b_we = 2'b01; b_adr = {32'h0, 32'h0000_1040};
    tick();
    check("wr_sreq",  128'(b_sreq),  128'h1);
    check("wr_sadr",  128'(b_sadr),  128'h0000_1040_0000_1040);
    check("wr_nogrant", 128'(b_grant), 128'h0);
    tick();
    check("wr_sreq_pulse", 128'(b_sreq), 128'h0);
    check("wr_sadr_hold",  128'(b_sadr), 128'h0000_1040_0000_1040);
    check("wr_wait", 128'(b_grant), 128'h0);
    tick();
    b_ack = 2'b10; b_hit = 2'b10;
    tick();
    b_ack = 2'b00; b_hit = 2'b00;
    check("wr_grant", 128'(b_grant), 128'h1);
    check("wr_idx",   128'(b_idx),   128'h0);
    check("wr_shit",  128'(b_shit),  128'h1);
    check("wr_sadr_idle", 128'(b_sadr), 128'h0);
    b_cyc = 2'b00; b_stb = 2'b00; b_we = 2'b00;
    tick();
    check("wr_release", 128'(b_grant), 128'h0);

    // Core0 write, core1 silent: timeout 15 cycles after SNOOP, grant the cycle after.
    b_cyc = 2'b01; b_stb = 2'b01; b_we = 2'b01; b_adr = {32'h0, 32'h0000_2000};
    tick();
    check("to_sreq", 128'(b_sreq), 128'h1);
    watch_timeout(t_at, pulses, g_at);
    check("to_when",   128'(t_at),   128'd15);
    check("to_pulses", 128'(pulses), 128'd1);
    check("to_grant_at", 128'(g_at), 128'd16);
    check("to_grant",  128'(b_grant), 128'h1);
    check("to_shit",   128'(b_shit),  128'h0);
    b_cyc = 2'b00; b_stb = 2'b00; b_we = 2'b00;
    tick();
    check("to_release", 128'(b_grant), 128'h0);

    // Core1 write with only its own ack/hit asserted: must still time out with no hit.
    b_cyc = 2'b10; b_stb = 2'b10; b_we = 2'b10; b_adr = {32'h0000_3000, 32'h0};
    b_ack = 2'b10; b_hit = 2'b10;
    tick();
    check("own_sreq", 128'(b_sreq), 128'h1);
    check("own_sadr", 128'(b_sadr), 128'h0000_3000_0000_3000);
    watch_timeout(t_at, pulses, g_at);
    check("own_when",   128'(t_at),    128'd15);
    check("own_pulses", 128'(pulses),  128'd1);
    check("own_grant",  128'(b_grant), 128'h2);
    check("own_idx",    128'(b_idx),   128'h1);
    check("own_shit",   128'(b_shit),  128'h0);
    b_ack = 2'b00; b_hit = 2'b00;

    // Reset while core1 owns the bus; afterwards the pointer is back at 0.
    rst = 1'b1;
    tick();
    check("mrst_grant", 128'(b_grant), 128'h0);
    check("mrst_sreq",  128'(b_sreq),  128'h0);
    rst = 1'b0;
    b_cyc = 2'b11; b_stb = 2'b11; b_we = 2'b00;
    tick();
    check("mrst_ptr0", 128'(b_grant), 128'h1);
    b_cyc = 2'b00; b_stb = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
